// File: rtl/dff_arb_pkg.sv
// Shared definitions for the write arbiter slice.
//   arb_state_t  : arbiter FSM states (IDLE, GRANT, RECOVER)
//   DEF_*        : default parameter values used by the interface and the top
package dff_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RECOVER = 2'd2
  } arb_state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 8;
  localparam int DEF_CNT_W   = 8;

endpackage

// File: rtl/dff_write_arbiter_if.sv
// Requester-side bus of the write arbiter.
//   req_i  : per-requester write request
//   data_i : per-requester write data, slice k belongs to requester k
//   gnt_o  : one-hot grant pulse
// Handshake: a requester raises req_i[k] with data slice k stable and holds
// both until it observes gnt_o[k] high for one cycle. The write is committed
// on the clock edge that ends that grant cycle, using the data present in the
// grant cycle; dropping req_i[k] during the grant cycle does not cancel it.
interface dff_write_arbiter_if
  import dff_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH
);

  logic [NUM_REQ-1:0]       req_i;
  logic [NUM_REQ*WIDTH-1:0] data_i;
  logic [NUM_REQ-1:0]       gnt_o;

  // master: the requesters; slave: the arbiter
  modport master (output req_i, output data_i, input gnt_o);
  modport slave  (input req_i, input data_i, output gnt_o);

endinterface

// File: rtl/dff_en_reg.sv
// Shared enabled register with asynchronous active-high reset to zero.
//   clk, rst : clock and async reset
//   en       : load enable
//   d / q    : data in / stored value
module dff_en_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/dff_write_arbiter.sv
// Round-robin write arbiter in front of one shared enabled register.
//   clk, rst       : clock, asynchronous active-high reset
//   bus (slave)    : req_i / data_i from requesters, gnt_o one-hot pulse back
//   q_o            : shared register contents
//   owner_o        : requester of the last committed write
//   busy_o         : high whenever the FSM is not IDLE
//   write_count_o  : committed writes, wrapping
//   state_o        : current FSM state (debug)
// One write takes IDLE -> GRANT -> RECOVER, so at most one write per 3 cycles.
module dff_write_arbiter
  import dff_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  dff_write_arbiter_if.slave         bus,
  output logic [WIDTH-1:0]           q_o,
  output logic [$clog2(NUM_REQ)-1:0] owner_o,
  output logic                       busy_o,
  output logic [CNT_W-1:0]           write_count_o,
  output arb_state_t                 state_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] winner_q, winner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt;
  logic             reg_en;
  logic [WIDTH-1:0] reg_d;

  // First requester found searching upward from ptr, wrapping at NUM_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        pick  = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      winner_q <= '0;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    gnt      = '0;
    reg_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req_i) begin
          state_d  = GRANT;
          winner_d = rr_pick(bus.req_i, rr_ptr_q);
        end
      end
      GRANT: begin
        gnt[winner_q] = 1'b1;
        reg_en        = 1'b1;
        state_d       = RECOVER;
        rr_ptr_d      = (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + IDX_W'(1);
        owner_d       = winner_q;
        cnt_d         = cnt_q + CNT_W'(1);
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Data of the latched winner feeds the register; only loaded in GRANT.
  always_comb begin
    reg_d = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (winner_q == IDX_W'(k)) begin
        reg_d = bus.data_i[k*WIDTH +: WIDTH];
      end
    end
  end

  dff_en_reg #(.WIDTH(WIDTH)) u_reg (
    .clk (clk),
    .rst (rst),
    .en  (reg_en),
    .d   (reg_d),
    .q   (q_o)
  );

  assign bus.gnt_o     = gnt;
  assign owner_o       = owner_q;
  assign busy_o        = (state_q != IDLE);
  assign write_count_o = cnt_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_dff_write_arbiter.sv
module tb_dff_write_arbiter;
  import dff_arb_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dff_write_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

  logic [W-1:0]  q_o;
  logic [1:0]    owner_o;
  logic          busy_o;
  logic [CW-1:0] cnt_o;
  arb_state_t    state_o;

  dff_write_arbiter #(.NUM_REQ(N), .WIDTH(W), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .q_o           (q_o),
    .owner_o       (owner_o),
    .busy_o        (busy_o),
    .write_count_o (cnt_o),
    .state_o       (state_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit cmp_en = 1'b0;
  logic [W-1:0] exp_q[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Behavioural model: a write is a 3-cycle transaction (grant cycle, then a
  // recovery cycle) started whenever nothing is in flight and someone requests.
  int           ph;   // cycles into the current transaction, 0 = none
  int           m_win, m_ptr, m_owner, m_cnt;
  logic [W-1:0] m_q;
  initial begin
    ph = 0; m_win = 0; m_ptr = 0; m_owner = 0; m_cnt = 0; m_q = '0;
  end

  function automatic int search(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return p;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph = 0; m_win = 0; m_ptr = 0; m_owner = 0; m_cnt = 0; m_q = '0;
    end else begin
      if (ph == 0) begin
        if (bus.req_i != '0) begin
          m_win = search(bus.req_i, m_ptr);
          ph = 1;
        end
      end else if (ph == 1) begin
        m_q     = bus.data_i[m_win*W +: W];
        m_owner = m_win;
        m_cnt   = (m_cnt + 1) % (1 << CW);
        m_ptr   = (m_win + 1) % N;
        ph      = 2;
      end else begin
        ph = 0;
      end
    end
  end

  // compare process
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_gnt",   bus.gnt_o, (ph == 1) ? (32'd1 << m_win) : 32'd0);
      chk("m_q",     q_o,       m_q);
      chk("m_owner", owner_o,   m_owner);
      chk("m_cnt",   cnt_o,     m_cnt);
      chk("m_busy",  busy_o,    (ph != 0) ? 32'd1 : 32'd0);
      chk("m_state", state_o,   (ph == 0) ? IDLE : (ph == 1) ? GRANT : RECOVER);
    end
  end

  // driver tasks
  task automatic set_data(input int k, input logic [W-1:0] v);
    bus.data_i[k*W +: W] = v;
  endtask

  task automatic do_reset();
    bus.req_i = '0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic wait_gnt(input string nm, output bit found, output int c);
    found = 1'b0;
    c = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (bus.gnt_o != '0) begin
        found = 1'b1;
        c = cyc;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s: no grant within 10 cycles, got none expected a grant", nm);
    end
  endtask

  initial begin
    bit           f;
    int           gc, last_gc;
    logic [W-1:0] v, last_v;
    logic [N-1:0] seen;
    int           order[5] = '{0, 1, 2, 3, 0};

    bus.req_i  = '0;
    bus.data_i = '0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cmp_en = 1'b1;

    // reset then idle
    repeat (10) begin
      @(negedge clk);
      chk("idle_q", q_o, 0);
      chk("idle_busy", busy_o, 0);
      chk("idle_gnt", bus.gnt_o, 0);
      chk("idle_cnt", cnt_o, 0);
    end

    // single write from requester 2
    @(posedge clk); #1;
    set_data(2, 8'hA5);
    bus.req_i = 4'b0100;
    @(negedge clk);
    chk("sw_pre_gnt", bus.gnt_o, 0);
    @(negedge clk);
    chk("sw_gnt", bus.gnt_o, 4'b0100);
    @(posedge clk); #1 bus.req_i = '0;
    @(negedge clk);
    chk("sw_q", q_o, 8'hA5);
    chk("sw_owner", owner_o, 2);
    chk("sw_cnt", cnt_o, 1);
    chk("sw_gnt_off", bus.gnt_o, 0);

    // round-robin fairness
    do_reset();
    for (int k = 0; k < N; k++) set_data(k, W'(8'h10 + k));
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    @(posedge clk); #1 bus.req_i = 4'b1111;
    last_gc = 0;
    for (int g = 0; g < 5; g++) begin
      wait_gnt("rr_wait", f, gc);
      if (f) begin
        chk("rr_gnt", bus.gnt_o, 32'd1 << order[g]);
        if (g > 0) chk("rr_space", gc - last_gc, 3);
        last_gc = gc;
      end
      @(posedge clk); #1;
      if (g == 4) bus.req_i = '0;
      @(negedge clk);
      chk("rr_q", q_o, exp_q.pop_front());
    end

    // counter wrap: 256 writes from requester 1
    do_reset();
    last_v = '0;
    for (int i = 1; i <= 256; i++) begin
      v = W'($urandom_range(0, 255));
      @(posedge clk); #1;
      set_data(1, v);
      bus.req_i = 4'b0010;
      wait_gnt("wrap_wait", f, gc);
      @(posedge clk); #1 bus.req_i = '0;
      last_v = v;
      @(negedge clk);
      if (i == 255) chk("wrap_cnt255", cnt_o, 255);
    end
    chk("wrap_cnt0", cnt_o, 0);
    chk("wrap_q", q_o, last_v);
    chk("wrap_owner", owner_o, 1);

    // reset during GRANT aborts the write
    @(posedge clk); #1;
    set_data(0, 8'h3C);
    bus.req_i = 4'b0001;
    wait_gnt("rm_wait0", f, gc);
    @(posedge clk); #1 bus.req_i = '0;
    @(negedge clk);
    chk("rm_q3c", q_o, 8'h3C);
    @(posedge clk); #1;
    set_data(0, 8'hFF);
    bus.req_i = 4'b0001;
    wait_gnt("rm_wait1", f, gc);
    #2 rst = 1'b1;
    #1;
    chk("rm_gnt_drop", bus.gnt_o, 0);
    chk("rm_q", q_o, 0);
    chk("rm_cnt", cnt_o, 0);
    chk("rm_state", state_o, IDLE);
    chk("rm_busy", busy_o, 0);
    bus.req_i = '0;
    @(negedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rm_q_after", q_o, 0);
    chk("rm_cnt_after", cnt_o, 0);

    // request dropped inside its grant cycle
    @(posedge clk); #1;
    set_data(3, 8'h77);
    bus.req_i = 4'b1000;
    wait_gnt("dr_wait", f, gc);
    chk("dr_gnt", bus.gnt_o, 4'b1000);
    #2 bus.req_i = '0;
    @(negedge clk);
    chk("dr_q", q_o, 8'h77);
    chk("dr_owner", owner_o, 3);
    chk("dr_cnt", cnt_o, 1);
    @(posedge clk); #1;
    set_data(0, 8'h5A);
    set_data(3, 8'h66);
    bus.req_i = 4'b1001;
    wait_gnt("dr_wait2", f, gc);
    chk("dr_next_gnt", bus.gnt_o, 4'b0001);
    @(posedge clk); #1 bus.req_i = 4'b1000;
    @(negedge clk);
    chk("dr_next_q", q_o, 8'h5A);
    wait_gnt("dr_wait3", f, gc);
    chk("dr_last_gnt", bus.gnt_o, 4'b1000);
    @(posedge clk); #1 bus.req_i = '0;

    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      seen = bus.gnt_o;
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
        if (bus.req_i[k] && seen[k]) begin
          bus.req_i[k] = ($urandom_range(0, 3) == 0);
          if (bus.req_i[k]) set_data(k, W'($urandom_range(0, 255)));
        end else if (!bus.req_i[k] && $urandom_range(0, 2) == 0) begin
          set_data(k, W'($urandom_range(0, 255)));
          bus.req_i[k] = 1'b1;
        end
      end
    end
    bus.req_i = '0;
    repeat (6) @(negedge clk);
    cmp_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
